// File: rtl/axi_traffic_chk.sv
// ---------------------------------------------------------------------------
// axi_traffic_chk
//   AXI4 master traffic generator / checker for the SDRAM AXI slave.
//   It writes NUM_BURSTS INCR bursts of an incrementing data pattern. It then
//   reads the same address range back and compares every beat. There are three
//   modes: write-only, read-only, and write-then-read.
//   It reports a saturating error count and the address of the first error.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i                starts a pass (only accepted in IDLE or DONE)
//   mode_i                 00 write-only, 01 read-only, 1x write-then-read
//   busy_o / done_o        pass in progress / pass finished
//   err_cnt_o              saturating count of data/response errors
//   first_err_addr_o       beat address of the first error
//   outport_aw*/w*/b*      AXI4 write address, data and response channels
//   outport_ar*/r*         AXI4 read address and data channels
// ---------------------------------------------------------------------------
module axi_traffic_chk #(
  parameter int          DATA_W     = 32,
  parameter int          BURST_LEN  = 8,
  parameter int          NUM_BURSTS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter logic [31:0] SEED       = 32'h01234567,
  parameter int          INCR       = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           err_cnt_o,
  output logic [31:0]           first_err_addr_o,
  output logic                  outport_awvalid_o,
  output logic [31:0]           outport_awaddr_o,
  output logic [3:0]            outport_awid_o,
  output logic [7:0]            outport_awlen_o,
  output logic [1:0]            outport_awburst_o,
  input  logic                  outport_awready_i,
  output logic                  outport_wvalid_o,
  output logic [DATA_W-1:0]     outport_wdata_o,
  output logic [DATA_W/8-1:0]   outport_wstrb_o,
  output logic                  outport_wlast_o,
  input  logic                  outport_wready_i,
  output logic                  outport_bready_o,
  input  logic                  outport_bvalid_i,
  input  logic [1:0]            outport_bresp_i,
  input  logic [3:0]            outport_bid_i,
  output logic                  outport_arvalid_o,
  output logic [31:0]           outport_araddr_o,
  output logic [3:0]            outport_arid_o,
  output logic [7:0]            outport_arlen_o,
  output logic [1:0]            outport_arburst_o,
  input  logic                  outport_arready_i,
  output logic                  outport_rready_o,
  input  logic                  outport_rvalid_i,
  input  logic [DATA_W-1:0]     outport_rdata_i,
  input  logic [1:0]            outport_rresp_i,
  input  logic [3:0]            outport_rid_i,
  input  logic                  outport_rlast_i
);

  localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [15:0]       LAST_BURST  = 16'(NUM_BURSTS - 1);
  localparam logic [31:0]       BEAT_BYTES  = 32'(DATA_W / 8);
  localparam logic [31:0]       BURST_BYTES = 32'(BURST_LEN * (DATA_W / 8));
  localparam logic [DATA_W-1:0] SEED_EXT    = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] INCR_EXT    = DATA_W'(INCR);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [15:0]       r_burst_cnt;
  logic [7:0]        r_beat;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_pattern;
  logic              r_do_read;
  logic [15:0]       r_err_cnt;
  logic [31:0]       r_first_err;

  logic              w_start_ok;
  logic              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic              w_last_beat, w_last_burst;
  logic              w_b_err, w_r_err, w_err;
  logic [31:0]       w_beat_addr, w_err_addr;
  logic              w_unused_ids;

  // IDs are always zero on the request side, so the returned IDs carry no information.
  assign w_unused_ids = ^{outport_bid_i, outport_rid_i};

  assign w_start_ok   = start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_aw_hs      = (r_state == S_AW) && outport_awready_i;
  assign w_w_hs       = (r_state == S_W)  && outport_wready_i;
  assign w_b_hs       = (r_state == S_B)  && outport_bvalid_i;
  assign w_ar_hs      = (r_state == S_AR) && outport_arready_i;
  assign w_r_hs       = (r_state == S_R)  && outport_rvalid_i;
  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign w_last_burst = (r_burst_cnt == LAST_BURST);

  assign w_beat_addr  = r_addr + ({24'd0, r_beat} * BEAT_BYTES);

  // Each read beat can raise at most one error, whatever mix of faults it has.
  assign w_b_err    = w_b_hs && (outport_bresp_i != 2'b00);
  assign w_r_err    = w_r_hs && ((outport_rdata_i != r_pattern) ||
                                 (outport_rresp_i != 2'b00) ||
                                 (outport_rlast_i != w_last_beat));
  assign w_err      = w_b_err || w_r_err;
  assign w_err_addr = w_b_err ? r_addr : w_beat_addr;

  // Request payloads are constant or held in registers.
  // This keeps them stable while valid waits for ready.
  assign outport_awaddr_o  = r_addr;
  assign outport_awid_o    = 4'd0;
  assign outport_awlen_o   = LAST_BEAT;
  assign outport_awburst_o = 2'b01;
  assign outport_wdata_o   = r_pattern;
  assign outport_wstrb_o   = '1;
  assign outport_wlast_o   = w_last_beat;
  assign outport_araddr_o  = r_addr;
  assign outport_arid_o    = 4'd0;
  assign outport_arlen_o   = LAST_BEAT;
  assign outport_arburst_o = 2'b01;
  assign err_cnt_o         = r_err_cnt;
  assign first_err_addr_o  = r_first_err;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic and per-state valid/ready strobes.
  always_comb begin
    w_next_state      = r_state;
    outport_awvalid_o = 1'b0;
    outport_wvalid_o  = 1'b0;
    outport_bready_o  = 1'b0;
    outport_arvalid_o = 1'b0;
    outport_rready_o  = 1'b0;
    busy_o            = 1'b1;
    done_o            = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        busy_o = 1'b0;
        done_o = (r_state == S_DONE);
        if (start_i) w_next_state = (mode_i == 2'b01) ? S_AR : S_AW;
      end
      S_AW: begin
        outport_awvalid_o = 1'b1;
        if (outport_awready_i) w_next_state = S_W;
      end
      S_W: begin
        outport_wvalid_o = 1'b1;
        if (outport_wready_i && w_last_beat) w_next_state = S_B;
      end
      S_B: begin
        outport_bready_o = 1'b1;
        if (outport_bvalid_i) begin
          if (!w_last_burst)  w_next_state = S_AW;
          else if (r_do_read) w_next_state = S_AR;
          else                w_next_state = S_DONE;
        end
      end
      S_AR: begin
        outport_arvalid_o = 1'b1;
        if (outport_arready_i) w_next_state = S_R;
      end
      S_R: begin
        outport_rready_o = 1'b1;
        // Leave on the beat count alone, so a wrong rlast cannot stall the checker.
        if (outport_rvalid_i && w_last_beat)
          w_next_state = w_last_burst ? S_DONE : S_AR;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Burst/beat counters, address, data pattern and error bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_burst_cnt <= '0;
      r_beat      <= '0;
      r_addr      <= BASE_ADDR;
      r_pattern   <= SEED_EXT;
      r_do_read   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (w_start_ok) begin
      r_burst_cnt <= '0;
      r_beat      <= '0;
      r_addr      <= BASE_ADDR;
      r_pattern   <= SEED_EXT;
      r_do_read   <= (mode_i != 2'b00);
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      if (w_w_hs || w_r_hs) begin
        r_pattern <= r_pattern + INCR_EXT;
        r_beat    <= w_last_beat ? 8'd0 : r_beat + 8'd1;
      end
      // The last write response restarts address and pattern for the read-back.
      if (w_b_hs) begin
        if (w_last_burst) begin
          r_burst_cnt <= '0;
          r_addr      <= BASE_ADDR;
          r_pattern   <= SEED_EXT;
        end else begin
          r_burst_cnt <= r_burst_cnt + 16'd1;
          r_addr      <= r_addr + BURST_BYTES;
        end
      end
      if (w_r_hs && w_last_beat && !w_last_burst) begin
        r_burst_cnt <= r_burst_cnt + 16'd1;
        r_addr      <= r_addr + BURST_BYTES;
      end
      if (w_err) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0)    r_first_err <= w_err_addr;
      end
    end
  end

endmodule

// File: tb/tb_axi_traffic_chk.sv
// ---------------------------------------------------------------------------
// tb_axi_traffic_chk
//   Scoreboard bench for axi_traffic_chk.
//   dut0 (8-beat bursts, 4 bursts) runs against a small memory slave that can
//   stall and inject faults. dut1 (1-beat bursts, 3 bursts) runs write-only
//   against an always-ready slave.
//   Expected AW/W/AR traffic is queued when a pass starts.
//   A negedge monitor pops and compares it.
// ---------------------------------------------------------------------------
module tb_axi_traffic_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1;
  logic [1:0]  mode0, mode1;
  int          total = 0;
  int          bad = 0;

  // dut0 signals
  logic        busy0, done0;
  logic [15:0] errCnt0;
  logic [31:0] firstErr0;
  logic        awValid0, awReady0, wValid0, wLast0, wReady0, bReady0, bValid0;
  logic [31:0] awAddr0, wData0, arAddr0, rData0;
  logic [3:0]  awId0, arId0, bId0, rId0, wStrb0;
  logic [7:0]  awLen0, arLen0;
  logic [1:0]  awBurst0, arBurst0, bResp0, rResp0;
  logic        arValid0, arReady0, rReady0, rValid0, rLast0;

  // dut1 signals
  logic        busy1, done1;
  logic [15:0] errCnt1;
  logic [31:0] firstErr1;
  logic        awValid1, awReady1, wValid1, wLast1, wReady1, bReady1, bValid1;
  logic [31:0] awAddr1, wData1, arAddr1, rData1;
  logic [3:0]  awId1, arId1, bId1, rId1, wStrb1;
  logic [7:0]  awLen1, arLen1;
  logic [1:0]  awBurst1, arBurst1, bResp1, rResp1;
  logic        arValid1, arReady1, rReady1, rValid1, rLast1;

  axi_traffic_chk #(.DATA_W(32), .BURST_LEN(8), .NUM_BURSTS(4), .BASE_ADDR(32'h0),
                    .SEED(32'h01234567), .INCR(8)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .mode_i(mode0),
    .busy_o(busy0), .done_o(done0), .err_cnt_o(errCnt0), .first_err_addr_o(firstErr0),
    .outport_awvalid_o(awValid0), .outport_awaddr_o(awAddr0), .outport_awid_o(awId0),
    .outport_awlen_o(awLen0), .outport_awburst_o(awBurst0), .outport_awready_i(awReady0),
    .outport_wvalid_o(wValid0), .outport_wdata_o(wData0), .outport_wstrb_o(wStrb0),
    .outport_wlast_o(wLast0), .outport_wready_i(wReady0),
    .outport_bready_o(bReady0), .outport_bvalid_i(bValid0), .outport_bresp_i(bResp0),
    .outport_bid_i(bId0),
    .outport_arvalid_o(arValid0), .outport_araddr_o(arAddr0), .outport_arid_o(arId0),
    .outport_arlen_o(arLen0), .outport_arburst_o(arBurst0), .outport_arready_i(arReady0),
    .outport_rready_o(rReady0), .outport_rvalid_i(rValid0), .outport_rdata_i(rData0),
    .outport_rresp_i(rResp0), .outport_rid_i(rId0), .outport_rlast_i(rLast0));

  axi_traffic_chk #(.DATA_W(32), .BURST_LEN(1), .NUM_BURSTS(3), .BASE_ADDR(32'h0),
                    .SEED(32'h01234567), .INCR(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .mode_i(mode1),
    .busy_o(busy1), .done_o(done1), .err_cnt_o(errCnt1), .first_err_addr_o(firstErr1),
    .outport_awvalid_o(awValid1), .outport_awaddr_o(awAddr1), .outport_awid_o(awId1),
    .outport_awlen_o(awLen1), .outport_awburst_o(awBurst1), .outport_awready_i(awReady1),
    .outport_wvalid_o(wValid1), .outport_wdata_o(wData1), .outport_wstrb_o(wStrb1),
    .outport_wlast_o(wLast1), .outport_wready_i(wReady1),
    .outport_bready_o(bReady1), .outport_bvalid_i(bValid1), .outport_bresp_i(bResp1),
    .outport_bid_i(bId1),
    .outport_arvalid_o(arValid1), .outport_araddr_o(arAddr1), .outport_arid_o(arId1),
    .outport_arlen_o(arLen1), .outport_arburst_o(arBurst1), .outport_arready_i(arReady1),
    .outport_rready_o(rReady1), .outport_rvalid_i(rValid1), .outport_rdata_i(rData1),
    .outport_rresp_i(rResp1), .outport_rid_i(rId1), .outport_rlast_i(rLast1));

  // Scoreboard queues and slave configuration
  logic [31:0] expAw0[$], expAr0[$], expAw1[$];
  logic [32:0] expW0[$], expW1[$];
  int          stallPct, corruptBurst, corruptBeat, badBBurst, earlyRlastBurst;
  int          wBurstIdx, rBurstIdx, wOrderErr, wHsCount0, bCount1, arCount1;
  logic        wActive, bPending, rActive;
  logic [31:0] wAddr, rAddr;
  int          wBeat, rBeat;
  logic [31:0] mem [0:31];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Memory slave for dut0.
  // It changes its outputs on the negedge and then samples handshakes.
  // The values it samples are the ones the next posedge will see.
  initial begin
    int idx;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    awReady0 = 0; wReady0 = 0; bValid0 = 0; bResp0 = 0; bId0 = 0;
    arReady0 = 0; rValid0 = 0; rData0 = 0; rResp0 = 0; rId0 = 0; rLast0 = 0;
    wActive = 0; bPending = 0; rActive = 0; wBeat = 0; rBeat = 0; wAddr = 0; rAddr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awReady0 = 0; wReady0 = 0; bValid0 = 0; arReady0 = 0; rValid0 = 0;
        wActive = 0; bPending = 0; rActive = 0; wBeat = 0; rBeat = 0;
      end else begin
        awReady0 = ($urandom_range(0, 99) >= stallPct);
        wReady0  = ($urandom_range(0, 99) >= stallPct);
        arReady0 = ($urandom_range(0, 99) >= stallPct);
        bValid0  = bPending;
        bResp0   = (wBurstIdx == badBBurst) ? 2'b10 : 2'b00;
        rValid0  = rActive && ($urandom_range(0, 99) >= stallPct);
        idx      = (int'(rAddr >> 2) + rBeat) & 31;
        rData0   = mem[idx] ^ ((rBurstIdx == corruptBurst && rBeat == corruptBeat) ?
                               32'hFFFF0000 : 32'h0);
        rLast0   = (rBurstIdx == earlyRlastBurst) ? (rBeat >= 6) : (rBeat == 7);
        if (awValid0 && awReady0) begin
          wActive = 1; wAddr = awAddr0; wBeat = 0;
        end
        if (wValid0 && wReady0) begin
          if (!wActive) wOrderErr++;
          idx = (int'(wAddr >> 2) + wBeat) & 31;
          mem[idx] = wData0;
          wBeat++;
          if (wBeat == 8) begin wActive = 0; bPending = 1; end
        end
        if (bValid0 && bReady0) begin bPending = 0; wBurstIdx++; end
        if (arValid0 && arReady0) begin rActive = 1; rAddr = arAddr0; rBeat = 0; end
        if (rValid0 && rReady0) begin
          rBeat++;
          if (rBeat == 8) begin rActive = 0; rBurstIdx++; end
        end
      end
    end
  end

  // Always-ready slave for dut1. It never returns read data.
  initial begin
    awReady1 = 1; wReady1 = 1; bValid1 = 1; bResp1 = 0; bId1 = 0;
    arReady1 = 1; rValid1 = 0; rData1 = 0; rResp1 = 0; rId1 = 0; rLast1 = 0;
  end

  // Monitor.
  // While a valid is up, its payload must match the head of the expected queue.
  // This also checks that the payload holds through stalls.
  // The head entry is popped when the handshake completes.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (awValid0) begin
          checkOutput("aw0_pending", 64'(expAw0.size() > 0), 1);
          checkOutput("aw0_ctrl", {awId0, awLen0, awBurst0}, {4'h0, 8'h07, 2'b01});
          if (expAw0.size() > 0) begin
            checkOutput("aw0_addr", awAddr0, expAw0[0]);
            if (awReady0) void'(expAw0.pop_front());
          end
        end
        if (wValid0) begin
          checkOutput("w0_pending", 64'(expW0.size() > 0), 1);
          checkOutput("w0_strb", wStrb0, 4'hF);
          if (expW0.size() > 0) begin
            checkOutput("w0_beat", {wLast0, wData0}, expW0[0]);
            if (wReady0) begin void'(expW0.pop_front()); wHsCount0++; end
          end
        end
        if (arValid0) begin
          checkOutput("ar0_pending", 64'(expAr0.size() > 0), 1);
          checkOutput("ar0_ctrl", {arId0, arLen0, arBurst0}, {4'h0, 8'h07, 2'b01});
          if (expAr0.size() > 0) begin
            checkOutput("ar0_addr", arAddr0, expAr0[0]);
            if (arReady0) void'(expAr0.pop_front());
          end
        end
        if (awValid1) begin
          checkOutput("aw1_pending", 64'(expAw1.size() > 0), 1);
          checkOutput("aw1_ctrl", {awId1, awLen1, awBurst1}, {4'h0, 8'h00, 2'b01});
          if (expAw1.size() > 0) begin
            checkOutput("aw1_addr", awAddr1, expAw1[0]);
            void'(expAw1.pop_front());
          end
        end
        if (wValid1) begin
          checkOutput("w1_pending", 64'(expW1.size() > 0), 1);
          checkOutput("w1_strb", wStrb1, 4'hF);
          if (expW1.size() > 0) begin
            checkOutput("w1_beat", {wLast1, wData1}, expW1[0]);
            void'(expW1.pop_front());
          end
        end
        if (bValid1 && bReady1) bCount1++;
        if (arValid1) arCount1++;
      end
    end
  end

  // Queue the expected traffic for one pass, then pulse start.
  task automatic applyStimulus(input int dutSel, input logic [1:0] m);
    if (dutSel == 0) begin
      expAw0.delete(); expW0.delete(); expAr0.delete();
      wBurstIdx = 0; rBurstIdx = 0; wOrderErr = 0; wHsCount0 = 0;
      if (m != 2'b01) begin
        for (int b = 0; b < 4; b++) expAw0.push_back(32'(b * 32));
        for (int k = 0; k < 32; k++)
          expW0.push_back({(k % 8 == 7), 32'h01234567 + 32'(k * 8)});
      end
      if (m != 2'b00)
        for (int b = 0; b < 4; b++) expAr0.push_back(32'(b * 32));
      mode0 = m; start0 = 1;
      @(posedge clk); #1;
      start0 = 0;
      checkOutput("req_latency", (m == 2'b01) ? arValid0 : awValid0, 1);
      checkOutput("req_addr", (m == 2'b01) ? arAddr0 : awAddr0, 32'h0);
      checkOutput("busy_after_start", busy0, 1);
      checkOutput("done_cleared", done0, 0);
    end else begin
      expAw1.delete(); expW1.delete();
      bCount1 = 0; arCount1 = 0;
      for (int k = 0; k < 3; k++) begin
        expAw1.push_back(32'(k * 4));
        expW1.push_back({1'b1, 32'h01234567 + 32'(k * 8)});
      end
      mode1 = m; start1 = 1;
      @(posedge clk); #1;
      start1 = 0;
      checkOutput("req_latency1", awValid1, 1);
    end
  endtask

  task automatic waitDone(input int dutSel);
    int n = 0;
    while (((dutSel == 0) ? done0 : done1) !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput((dutSel == 0) ? "done0" : "done1", (dutSel == 0) ? done0 : done1, 1);
  endtask

  task automatic checkPass0(input logic [15:0] errs, input logic [31:0] firstAddr);
    checkOutput("err_cnt", errCnt0, errs);
    checkOutput("first_err_addr", firstErr0, firstAddr);
    checkOutput("busy_at_done", busy0, 0);
    checkOutput("left_aw", expAw0.size(), 0);
    checkOutput("left_w", expW0.size(), 0);
    checkOutput("left_ar", expAr0.size(), 0);
    checkOutput("w_before_aw", wOrderErr, 0);
  endtask

  initial begin
    rst = 1; start0 = 0; start1 = 0; mode0 = 0; mode1 = 0;
    stallPct = 0; corruptBurst = -1; corruptBeat = -1; badBBurst = -1; earlyRlastBurst = -1;
    wBurstIdx = 0; rBurstIdx = 0; wOrderErr = 0; wHsCount0 = 0; bCount1 = 0; arCount1 = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valids", {awValid0, wValid0, bReady0, arValid0, rReady0}, 0);
    checkOutput("rst_status", {busy0, done0}, 0);
    checkOutput("rst_err", errCnt0, 0);
    checkOutput("rst_first", firstErr0, 0);
    rst = 0;
    @(posedge clk); #1;

    $display("[TB] write-then-read, ideal slave");
    applyStimulus(0, 2'b10); waitDone(0); checkPass0(16'd0, 32'h0);

    $display("[TB] read-only over the written range");
    applyStimulus(0, 2'b01); waitDone(0); checkPass0(16'd0, 32'h0);

    $display("[TB] read data corrupted on burst 2 beat 3");
    corruptBurst = 2; corruptBeat = 3;
    applyStimulus(0, 2'b10); waitDone(0); checkPass0(16'd1, 32'h4C);
    corruptBurst = -1; corruptBeat = -1;

    $display("[TB] random 30 percent slave stalls");
    stallPct = 30;
    applyStimulus(0, 2'b11); waitDone(0); checkPass0(16'd0, 32'h0);
    stallPct = 0;

    $display("[TB] single-beat bursts, write-only");
    applyStimulus(1, 2'b00); waitDone(1);
    checkOutput("b1_count", bCount1, 3);
    checkOutput("ar1_count", arCount1, 0);
    checkOutput("err1", errCnt1, 0);
    checkOutput("left_w1", expW1.size(), 0);

    $display("[TB] bad bresp on burst 0, early rlast on read burst 1");
    badBBurst = 0; earlyRlastBurst = 1;
    applyStimulus(0, 2'b10); waitDone(0); checkPass0(16'd2, 32'h0);
    badBBurst = -1; earlyRlastBurst = -1;

    $display("[TB] reset in the middle of the write phase");
    applyStimulus(0, 2'b10);
    for (int n = 0; n < 200 && wHsCount0 < 3; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_w_reached", 64'(wHsCount0 >= 3), 1);
    rst = 1;
    @(posedge clk); #1;
    checkOutput("rst_mid_valids", {awValid0, wValid0, bReady0, arValid0, rReady0}, 0);
    checkOutput("rst_mid_status", {busy0, done0}, 0);
    checkOutput("rst_mid_err", {errCnt0, firstErr0}, 0);
    rst = 0;
    @(posedge clk); #1;
    applyStimulus(0, 2'b10); waitDone(0); checkPass0(16'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
